// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg: shared Game Boy memory-map constants, OAM DMA state type and source-page fold helper
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG_ADDR      = 16'hFF46;
    localparam logic [15:0] OAM_BASE          = 16'hFE00;
    localparam logic [15:0] HRAM_LO           = 16'hFF80;
    localparam logic [15:0] HRAM_HI           = 16'hFFFE;
    localparam int          OAM_BYTES_DEFAULT = 160;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        XFER,
        DRAIN
    } dma_state_t;

    // Pages E0-FF are echo RAM; they alias work RAM 0x2000 lower.
    function automatic logic [7:0] fold_src(input logic [7:0] hi);
        return (hi >= 8'hE0) ? hi - 8'h20 : hi;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// oam_dma: FF46-triggered 160-byte copy from {page,00} into OAM; OAM_DMA_READBACK_EN exposes the last FF46 value on reg_rd_data
module oam_dma
    import gb_mem_pkg::*;
#(
    parameter int OAM_BYTES   = OAM_BYTES_DEFAULT,
    parameter int START_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    input  logic        step_en,
    input  logic [7:0]  mem_data_in,
    output logic        dma_active,
    output logic        dma_rd_en,
    output logic [15:0] dma_src_addr,
    output logic        oam_wren,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic [7:0]  reg_rd_data,
    output logic        reg_hit
);

    localparam logic [7:0] LAST_IDX  = 8'(OAM_BYTES - 1);
    localparam logic [7:0] START_CNT = 8'(START_DELAY);

    dma_state_t state_q, state_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] idx_q, idx_d;
    logic       pend_valid_q;
    logic [7:0] pend_idx_q;
    logic       reg_wr;

    assign reg_hit      = (cpu_addr == DMA_REG_ADDR);
    assign reg_wr       = cpu_wren && reg_hit;
    // A register write in the same cycle as a strobe takes priority and suppresses the read.
    assign dma_rd_en    = (state_q == XFER) && step_en && !reg_wr;
    assign dma_src_addr = dma_rd_en ? {fold_src(src_hi_q), idx_q} : 16'h0000;
    assign dma_active   = (state_q != IDLE);
    assign oam_wren     = pend_valid_q;
    assign oam_addr     = pend_idx_q;
    assign oam_data     = mem_data_in;

`ifdef OAM_DMA_READBACK_EN
    assign reg_rd_data = src_hi_q;
`else
    assign reg_rd_data = 8'hFF;
`endif

    // Next-state logic: register writes (re)start the delay, strobes advance delay and transfer.
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (reg_wr) begin
            state_d  = DELAY;
            src_hi_d = cpu_data_in;
            cnt_d    = START_CNT;
        end else begin
            case (state_q)
                DELAY: if (step_en) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        idx_d   = 8'd0;
                        state_d = XFER;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                XFER: if (step_en) begin
                    if (idx_q == LAST_IDX) state_d = DRAIN;
                    else idx_d = idx_q + 8'd1;
                end
                DRAIN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers plus the one-entry write pipeline that turns each read into an OAM write next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            src_hi_q     <= 8'hFF;
            cnt_q        <= 8'd0;
            idx_q        <= 8'd0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            src_hi_q     <= src_hi_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_valid_q <= dma_rd_en;
            if (dma_rd_en) pend_idx_q <= idx_q;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized scoreboard bench for oam_dma against a per-transfer reference of reads and OAM writes
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = 16'hC000;
    logic        cpu_wren = 1'b0;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        step_en = 1'b0;
    logic [7:0]  mem_data_in = 8'h00;
    logic        dma_active, dma_rd_en, oam_wren, reg_hit;
    logic [15:0] dma_src_addr;
    logic [7:0]  oam_addr, oam_data, reg_rd_data;

    int n_chk = 0, n_pass = 0, n_rd = 0, step_div = 1, scyc = 0;
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];

    oam_dma dut (
        .clock(clock), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
        .cpu_data_in(cpu_data_in), .step_en(step_en), .mem_data_in(mem_data_in),
        .dma_active(dma_active), .dma_rd_en(dma_rd_en), .dma_src_addr(dma_src_addr),
        .oam_wren(oam_wren), .oam_addr(oam_addr), .oam_data(oam_data),
        .reg_rd_data(reg_rd_data), .reg_hit(reg_hit)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Source memory: synchronous read, data valid the cycle after the request.
    always @(posedge clock) if (dma_rd_en) mem_data_in <= mem_f(dma_src_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    endtask

    // Reference: a write of v copies 160 bytes from page v (echo pages E0-FF moved down by 0x20).
    task automatic push_xfer(input logic [7:0] v);
        logic [7:0]  page;
        logic [15:0] a;
        page = (v >= 8'hE0) ? v - 8'h20 : v;
        for (int i = 0; i < 160; i++) begin
            a = {page, 8'(i)};
            exp_rd.push_back(a);
            exp_wr.push_back({8'(i), mem_f(a)});
        end
    endtask

    task automatic do_write(input logic [7:0] v, input bit restart);
        @(posedge clock); #1;
        if (restart) begin
            exp_rd.delete();
            while (exp_wr.size() > 1) void'(exp_wr.pop_back());
        end
        push_xfer(v);
        cpu_wren = 1'b1; cpu_addr = 16'hFF46; cpu_data_in = v;
        @(posedge clock); #1;
        cpu_wren = 1'b0; cpu_addr = 16'hC000;
    endtask

    task automatic wait_rd(input int target);
        for (int i = 0; i < 3000; i++) begin
            if (n_rd >= target) return;
            @(negedge clock); #1;
        end
        chk("wait_rd_timeout", n_rd, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock); #1;
            if (exp_rd.size() == 0 && exp_wr.size() == 0 && !dma_active) break;
        end
        chk("drain_rd_left", exp_rd.size(), 0);
        chk("drain_wr_left", exp_wr.size(), 0);
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic chk_reset_outs();
        chk("rst_strobes", {dma_active, dma_rd_en, oam_wren}, 0);
        chk("rst_oam_addr", oam_addr, 0);
        chk("rst_src_addr", dma_src_addr, 0);
        chk("rst_reg_rd", reg_rd_data, 8'hFF);
    endtask

    // Strobe generator: step_en every step_div-th cycle.
    initial forever begin
        @(posedge clock); #1;
        scyc++;
        step_en = (step_div <= 1) || (scyc % step_div == 0);
    end

    // Monitor: pops expectations whenever the DUT issues a read or an OAM write.
    int cyc = 0, t_wr = -100;
    bit aw_rd = 0, aw_wr = 0, prev_rd = 0, chk_fall = 0;
    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            prev_rd = 0; aw_rd = 0; aw_wr = 0; chk_fall = 0;
        end else begin
            if (chk_fall) begin chk("active_fall", dma_active, 0); chk_fall = 0; end
            if (cyc == t_wr + 1) chk("active_rise", dma_active, 1);
            if (prev_rd || oam_wren) chk("wr_follows_rd", oam_wren, prev_rd);
            if (oam_wren) begin
                chk("oam_write", {oam_addr, oam_data}, exp_wr.size() != 0 ? {16'h0, exp_wr.pop_front()} : 32'hDEAD0000);
                if (aw_wr) begin
                    if (step_div == 1) chk("first_wr_lat", cyc - t_wr, 3);
                    aw_wr = 0;
                end
                if (exp_wr.size() == 0 && exp_rd.size() == 0) begin
                    chk("active_last", dma_active, 1);
                    chk_fall = 1;
                end
            end
            if (dma_rd_en) begin
                chk("rd_addr", dma_src_addr, exp_rd.size() != 0 ? {16'h0, exp_rd.pop_front()} : 32'hDEAD0000);
                n_rd++;
                if (aw_rd) begin
                    if (step_div == 1) chk("first_rd_lat", cyc - t_wr, 2);
                    aw_rd = 0;
                end
            end
            prev_rd = dma_rd_en;
            if (cpu_wren && cpu_addr == 16'hFF46) begin t_wr = cyc; aw_rd = 1; aw_wr = 1; end
        end
    end

    initial begin
        int base;
        #3;
        chk_reset_outs();
        @(posedge clock); #3 reset_n = 1'b1;
        step_div = 1;
        do_write(8'hC1, 0); wait_idle();
        do_write(8'hFE, 0); wait_idle();
        do_write(8'h80, 0); wait_idle();
        base = n_rd;
        do_write(8'hC2, 0); wait_rd(base + 50);
        do_write(8'hD0, 1); wait_idle();
        step_div = 4;
        do_write(8'($urandom), 0); wait_idle();
        step_div = 1;
        base = n_rd;
        do_write(8'($urandom), 0); wait_rd(base + 80);
        @(posedge clock); #2;
        reset_n = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        #1;
        chk_reset_outs();
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        do_write(8'($urandom), 0); wait_idle();
        do_write(8'h3A, 0);
        cpu_addr = 16'hFF46; #1;
        chk("reg_hit_ff46", reg_hit, 1);
`ifdef OAM_DMA_READBACK_EN
        chk("reg_readback", reg_rd_data, 8'h3A);
`else
        chk("reg_readback", reg_rd_data, 8'hFF);
`endif
        cpu_addr = 16'hFF47; #1;
        chk("reg_hit_other", reg_hit, 0);
        cpu_addr = 16'hC000;
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            step_div = int'($urandom_range(1, 3));
            do_write(8'($urandom), 0); wait_idle();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
